iter_divider: RTL and testbench

- Multi-cycle integer divide/remainder unit for the RV64M execution stage: DIV, DIVU, REM, REMU.
- Radix-2 restoring algorithm, one quotient bit per cycle, using a single SIZE+1-bit trial subtractor.
- Sits beside the combinational ALU in the datapath; the control unit holds the pipeline while busy is high.
- Divide-by-zero and signed overflow produce the architecturally mandated results.

---
 rtl/iter_divider_if.sv | 14 +
 rtl/iter_divider.sv | 137 +++++++++++++
 tb/tb_iter_divider.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/iter_divider_if.sv
// Request/response bundle for iter_divider: operands and opcode in, busy/done/result out.
interface iter_divider_if #(parameter int unsigned SIZE = 64);
   logic            start;
   logic [SIZE-1:0] s1;
   logic [SIZE-1:0] s2;
   logic            signed_op;
   logic            rem_sel;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] res;

   modport master (output start, s1, s2, signed_op, rem_sel, input busy, done, res);
   modport slave  (input start, s1, s2, signed_op, rem_sel, output busy, done, res);
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divide/remainder unit (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_REUSE_EN to keep the last result pair so a matching DIV/REM follow-up finishes at once.
module iter_divider #(
   parameter int unsigned SIZE = 64
) (
   input logic     clk,
   input logic     rst,
   iter_divider_if.slave bus
);
   localparam int unsigned CW = $clog2(SIZE + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_FIX, ST_DONE} state_t;

   state_t          state, state_nx;
   logic [SIZE-1:0] quo, rem, dvs, res_r;
   logic            neg_q, neg_r, rsel;
   logic [CW-1:0]   cnt;
   logic            div_zero, reuse_hit, last_iter;
   logic [SIZE:0]   trial;
   logic [SIZE-1:0] mag_s1, mag_s2, quo_fix, rem_fix, reuse_res;

   assign div_zero  = (bus.s2 == '0);
   assign mag_s1    = (bus.signed_op && bus.s1[SIZE-1]) ? -bus.s1 : bus.s1;
   assign mag_s2    = (bus.signed_op && bus.s2[SIZE-1]) ? -bus.s2 : bus.s2;
   assign trial     = {rem, quo[SIZE-1]} - {1'b0, dvs};
   assign last_iter = (cnt == CW'(SIZE - 1));
   assign quo_fix   = neg_q ? -quo : quo;
   assign rem_fix   = neg_r ? -rem : rem;

`ifdef DIV_REUSE_EN
   logic [SIZE-1:0] op_s1, op_s2, last_s1, last_s2, last_quo, last_rem;
   logic            op_signed, last_signed, last_valid;

   assign reuse_hit = last_valid && (bus.s1 == last_s1) && (bus.s2 == last_s2) &&
                      (bus.signed_op == last_signed);
   assign reuse_res = bus.rem_sel ? last_rem : last_quo;

   // Raw operands are parked until FIX so an aborted run never becomes a reuse candidate.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_s1       <= '0;
         op_s2       <= '0;
         op_signed   <= 1'b0;
         last_s1     <= '0;
         last_s2     <= '0;
         last_signed <= 1'b0;
         last_quo    <= '0;
         last_rem    <= '0;
         last_valid  <= 1'b0;
      end else if ((state == ST_IDLE || state == ST_DONE) && bus.start) begin
         op_s1     <= bus.s1;
         op_s2     <= bus.s2;
         op_signed <= bus.signed_op;
      end else if (state == ST_FIX) begin
         last_s1     <= op_s1;
         last_s2     <= op_s2;
         last_signed <= op_signed;
         last_quo    <= quo_fix;
         last_rem    <= rem_fix;
         last_valid  <= 1'b1;
      end
   end
`else
   assign reuse_hit = 1'b0;
   assign reuse_res = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            bus.done = (state == ST_DONE);
            if (bus.start) state_nx = (div_zero || reuse_hit) ? ST_DONE : ST_DIV;
            else           state_nx = ST_IDLE;
         end
         ST_DIV: begin
            bus.busy = 1'b1;
            if (last_iter) state_nx = ST_FIX;
         end
         ST_FIX: begin
            bus.busy = 1'b1;
            state_nx = ST_DONE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         res_r <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         rsel  <= 1'b0;
         cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  rsel  <= bus.rem_sel;
                  neg_q <= bus.signed_op & (bus.s1[SIZE-1] ^ bus.s2[SIZE-1]);
                  neg_r <= bus.signed_op & bus.s1[SIZE-1];
                  dvs   <= mag_s2;
                  quo   <= mag_s1;
                  rem   <= '0;
                  cnt   <= '0;
                  if (div_zero)       res_r <= bus.rem_sel ? bus.s1 : '1;
                  else if (reuse_hit) res_r <= reuse_res;
               end
            end
            ST_DIV: begin
               // A set trial[SIZE] is the borrow: keep the shifted remainder, quotient bit 0.
               rem <= trial[SIZE] ? {rem[SIZE-2:0], quo[SIZE-1]} : trial[SIZE-1:0];
               quo <= {quo[SIZE-2:0], ~trial[SIZE]};
               cnt <= cnt + CW'(1);
            end
            ST_FIX: begin
               quo   <= quo_fix;
               rem   <= rem_fix;
               res_r <= rsel ? rem_fix : quo_fix;
            end
            default: ;
         endcase
      end
   end

   assign bus.res = res_r;
endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed vectors queue expected result and latency, a monitor checks each done.
module tb_iter_divider;
   localparam int unsigned SIZE       = 64;
   localparam int unsigned LAT_FULL   = SIZE + 1;  // accept edge to done edge through DIV and FIX
   localparam int unsigned LAT_DIRECT = 0;         // accept edge lands straight in DONE
   localparam logic [SIZE-1:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;

   iter_divider_if #(.SIZE(SIZE)) dif ();
   iter_divider #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(dif.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [SIZE-1:0] res;
      int unsigned     lat;
      int unsigned     acc;
      string           name;
   } exp_t;

   exp_t            exp_q[$];
   exp_t            mon_e;
   int unsigned     cyc = 0;
   int unsigned     checks = 0;
   int unsigned     failures = 0;
   logic [SIZE-1:0] m_s1, m_s2;
   logic            m_sg;
   logic            m_valid = 1'b0;
   int unsigned     lat;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && dif.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done res=%h required=no_done", dif.res);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_res"}, dif.res, mon_e.res);
            check({mon_e.name, "_lat"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
         end
      end
   end

   // Called at a negedge while the DUT is in IDLE or DONE; returns at the negedge after the accept edge.
   task automatic issue(input string nm, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic sg, input logic rs, input logic [SIZE-1:0] r,
                        output int unsigned l);
      exp_t e;
      if (b == '0) l = LAT_DIRECT;
`ifdef DIV_REUSE_EN
      else if (m_valid && a == m_s1 && b == m_s2 && sg == m_sg) l = LAT_DIRECT;
`endif
      else begin
         l       = LAT_FULL;
         m_s1    = a;
         m_s2    = b;
         m_sg    = sg;
         m_valid = 1'b1;
      end
      e.res  = r;
      e.lat  = l;
      e.acc  = cyc + 1;
      e.name = nm;
      exp_q.push_back(e);
      dif.start     = 1'b1;
      dif.s1        = a;
      dif.s2        = b;
      dif.signed_op = sg;
      dif.rem_sel   = rs;
      @(negedge clk);
      dif.start = 1'b0;
   endtask

   // Waits (bounded) for done; exp_busy < 0 skips the busy-cycle count check.
   task automatic wait_done(input int exp_busy);
      int  nb = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (dif.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (dif.busy === 1'b1) nb++;
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done");
      end else if (exp_busy >= 0) begin
         checks++;
         if (nb != exp_busy) begin
            failures++;
            $display("FAIL busy_cycles actual=%0d required=%0d", nb, exp_busy);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      dif.start     = 1'b0;
      dif.s1        = '0;
      dif.s2        = '0;
      dif.signed_op = 1'b0;
      dif.rem_sel   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(dif.busy), 64'd0);
      check("reset_done", 64'(dif.done), 64'd0);
      check("reset_res", dif.res, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, lat);
      wait_done(int'(lat));
      issue("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, lat);
      wait_done(int'(lat));
      @(negedge clk);

      issue("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, lat);
      wait_done(int'(lat));
      issue("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, ONES, lat);
      wait_done(int'(lat));
      issue("rem_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 64'd1, lat);
      wait_done(int'(lat));

      issue("divu_5_0", 64'd5, 64'd0, 1'b0, 1'b0, ONES, lat);
      wait_done(int'(lat));
      issue("rem_m5_0", 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, lat);
      wait_done(int'(lat));

      issue("div_ovf", 64'h8000_0000_0000_0000, ONES, 1'b1, 1'b0, 64'h8000_0000_0000_0000, lat);
      wait_done(int'(lat));
      issue("rem_ovf", 64'h8000_0000_0000_0000, ONES, 1'b1, 1'b1, 64'd0, lat);
      wait_done(int'(lat));
      @(negedge clk);

      // A start pulse with fresh operands mid-division must be ignored.
      issue("divu_1000_7", 64'd1000, 64'd7, 1'b0, 1'b0, 64'd142, lat);
      repeat (10) @(negedge clk);
      dif.start     = 1'b1;
      dif.s1        = 64'd50;
      dif.s2        = 64'd5;
      dif.signed_op = 1'b1;
      dif.rem_sel   = 1'b1;
      @(negedge clk);
      dif.start = 1'b0;
      wait_done(-1);
      @(negedge clk);

      // Abort a division with reset; no done may follow.
      dif.start     = 1'b1;
      dif.s1        = 64'd1000;
      dif.s2        = 64'd3;
      dif.signed_op = 1'b0;
      dif.rem_sel   = 1'b0;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(dif.busy), 64'd0);
      check("abort_done", 64'(dif.done), 64'd0);
      check("abort_res", dif.res, 64'd0);
      rst     = 1'b0;
      m_valid = 1'b0;
      repeat (80) @(negedge clk);

      issue("divu_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, lat);
      wait_done(int'(lat));
      @(negedge clk);

      issue("div_100_7", 64'd100, 64'd7, 1'b1, 1'b0, 64'd14, lat);
      wait_done(int'(lat));
      issue("rem_100_7", 64'd100, 64'd7, 1'b1, 1'b1, 64'd2, lat);
      wait_done(int'(lat));
      issue("rem_100_8", 64'd100, 64'd8, 1'b1, 1'b1, 64'd4, lat);
      wait_done(int'(lat));

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL pending_results actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
